wbh_reset_seq: RTL

//  Power-on / software reset sequencer for the wb_host subsystem resets. After
//  PLL lock is qualified, it releases the seven user-project domain resets in a

---
 rtl/wbh_reset_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/wbh_reset_seq.sv
// wb_host reset sequencer: qualifies PLL lock, then releases the seven domain resets in order.
// Optional WAIT_LOCK watchdog is compiled in when RST_SEQ_WDOG_EN is defined.
module wbh_reset_seq #(
   parameter int unsigned GAP_CYCLES  = 16,
   parameter int unsigned LOCK_FILT   = 8,
   parameter int unsigned WDOG_CYCLES = 1024
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       cfg_seq_en,
   input  logic       pll_lock,
   input  logic [5:0] cfg_soft_rst,
   output logic       wb_rst_n,
   output logic       spi_rst_n,
   output logic       sdram_rst_n,
   output logic       uart_rst_n,
   output logic       i2cm_rst_n,
   output logic       usb_rst_n,
   output logic       cpu_rst_n,
   output logic       seq_done,
   output logic       seq_err,
   output logic [2:0] seq_state
);

   localparam int unsigned NUM_STAGES = 7;
   localparam int unsigned IDX_W      = 3;
   localparam int unsigned LOCK_W     = 8;
   localparam int unsigned GAP_W      = 16;

   localparam logic [IDX_W-1:0]  IDX_END  = IDX_W'(NUM_STAGES);
   localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_FILT);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   if (GAP_CYCLES < 1 || GAP_CYCLES > 65535 || LOCK_FILT < 1 || LOCK_FILT > 255 ||
       WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_param_check
      $error("wbh_reset_seq: parameter out of range");
   end

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_RELEASE   = 3'd2,
      ST_DONE      = 3'd3,
      ST_ERR       = 3'd4
   } state_t;

   state_t                  state;
   logic [LOCK_W-1:0]       lock_cnt;
   logic [GAP_W-1:0]        gap_cnt;
   logic [IDX_W-1:0]        stage_idx;
   logic [NUM_STAGES-1:0]   rst_n_q;
   logic [NUM_STAGES-1:0]   hold_mask;

   // wb (stage 0) has no soft-reset bit and is never held back
   assign hold_mask = {cfg_soft_rst, 1'b0};

`ifdef RST_SEQ_WDOG_EN
   localparam int unsigned WDOG_W = 16;
   localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(WDOG_CYCLES);

   logic [WDOG_W-1:0] wdog_cnt;
   logic              seq_err_q;

   assign seq_err = seq_err_q;
`else
   assign seq_err = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !cfg_seq_en) begin
         state     <= ST_IDLE;
         lock_cnt  <= '0;
         gap_cnt   <= '0;
         stage_idx <= '0;
         rst_n_q   <= '0;
         seq_done  <= 1'b0;
`ifdef RST_SEQ_WDOG_EN
         wdog_cnt  <= '0;
         seq_err_q <= 1'b0;
`endif
      end else if (!pll_lock && (state == ST_RELEASE || state == ST_DONE)) begin
         // lock lost: restart qualification, sequence will restart from stage 0
         state     <= ST_WAIT_LOCK;
         lock_cnt  <= '0;
         gap_cnt   <= '0;
         stage_idx <= '0;
         rst_n_q   <= '0;
         seq_done  <= 1'b0;
`ifdef RST_SEQ_WDOG_EN
         wdog_cnt  <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_WAIT_LOCK;
               lock_cnt <= '0;
`ifdef RST_SEQ_WDOG_EN
               wdog_cnt <= '0;
`endif
            end
            ST_WAIT_LOCK: begin
               if (pll_lock && lock_cnt == LOCK_LIM) begin
                  state     <= ST_RELEASE;
                  stage_idx <= '0;
                  gap_cnt   <= '0;
               end
`ifdef RST_SEQ_WDOG_EN
               else if (wdog_cnt == WDOG_LIM) begin
                  state     <= ST_ERR;
                  seq_err_q <= 1'b1;
               end
`endif
               else begin
                  lock_cnt <= pll_lock ? lock_cnt + LOCK_W'(1) : '0;
`ifdef RST_SEQ_WDOG_EN
                  wdog_cnt <= wdog_cnt + WDOG_W'(1);
`endif
               end
            end
            ST_RELEASE: begin
               if (stage_idx == IDX_END) begin
                  state    <= ST_DONE;
                  seq_done <= 1'b1;
               end else if (gap_cnt == GAP_LAST) begin
                  if (!hold_mask[stage_idx]) rst_n_q[stage_idx] <= 1'b1;
                  stage_idx <= stage_idx + IDX_W'(1);
                  gap_cnt   <= '0;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            ST_DONE: rst_n_q <= {~cfg_soft_rst, 1'b1};
            ST_ERR:  ;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign wb_rst_n    = rst_n_q[0];
   assign spi_rst_n   = rst_n_q[1];
   assign sdram_rst_n = rst_n_q[2];
   assign uart_rst_n  = rst_n_q[3];
   assign i2cm_rst_n  = rst_n_q[4];
   assign usb_rst_n   = rst_n_q[5];
   assign cpu_rst_n   = rst_n_q[6];
   assign seq_state   = state;

endmodule
